// File: rtl/bdl_ctl.sv
// rtl/bdl_ctl.sv - buffer descriptor list controller
// Fetches and chains descriptors over a DMA master, mirrors words into a register file, writes back status.
module bdl_ctl (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        fetch_i,
  input  logic        wrst_i,
  input  logic [21:0] base_i,
  input  logic [15:0] sw1_i,
  input  logic [15:0] sw2_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [21:0] dm_adr_o,
  output logic [15:0] dm_dat_o,
  input  logic [15:0] dm_dat_i,
  input  logic        dm_ack_i,
  input  logic        dm_err_i,
  output logic [2:0]  dma_adr_o,
  output logic [15:0] dma_dat_o,
  output logic        dma_we_o,
  output logic        dma_stb_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic        eol_o,
  output logic        nxm_o,
  output logic        cherr_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLAG, S_RD, S_STORE, S_CHK, S_SW2, S_SW1, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] cur_base_q, cur_base_d;
  logic [3:0]  chain_q, chain_d;
  logic [1:0]  rd_idx_q, rd_idx_d;
  logic [15:0] w1_q, w1_d, w2_q, w2_d;
  logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [21:0] dm_adr_q, dm_adr_d;
  logic [15:0] dm_dat_q, dm_dat_d;
  logic [2:0]  dma_adr_q, dma_adr_d;
  logic [15:0] dma_dat_q, dma_dat_d;
  logic        dma_we_q, dma_we_d, dma_stb_q, dma_stb_d;
  logic        busy_q, busy_d, valid_q, valid_d, eol_q, eol_d;
  logic        nxm_q, nxm_d, cherr_q, cherr_d, done_q, done_d;
  logic        bus_ok, bus_err;

  // Completions only count while a request is actually outstanding; error beats ack.
  assign bus_err = dm_req_q & dm_err_i;
  assign bus_ok  = dm_req_q & dm_ack_i & ~dm_err_i;

  always_comb begin
    state_d    = state_q;
    cur_base_d = cur_base_q;
    chain_d    = chain_q;
    rd_idx_d   = rd_idx_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_adr_d   = dm_adr_q;
    dm_dat_d   = dm_dat_q;
    dma_adr_d  = dma_adr_q;
    dma_dat_d  = dma_dat_q;
    dma_we_d   = 1'b0;
    dma_stb_d  = 1'b0;
    busy_d     = busy_q;
    valid_d    = valid_q;
    eol_d      = eol_q;
    nxm_d      = nxm_q;
    cherr_d    = cherr_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fetch_i) begin
          cur_base_d = {base_i[21:1], 1'b0};
          valid_d    = 1'b0;
          eol_d      = 1'b0;
          nxm_d      = 1'b0;
          cherr_d    = 1'b0;
          chain_d    = 4'd0;
          busy_d     = 1'b1;
          state_d    = S_FLAG;
        end else if (wrst_i && valid_q) begin
          busy_d  = 1'b1;
          state_d = S_SW2;
        end
      end
      S_FLAG: begin
        if (!dm_req_q) begin
          dm_req_d = 1'b1;
          dm_we_d  = 1'b1;
          dm_adr_d = cur_base_q;
          dm_dat_d = 16'h4000;
        end else if (bus_ok) begin
          dm_req_d  = 1'b0;
          dma_stb_d = 1'b1;
          dma_we_d  = 1'b1;
          dma_adr_d = 3'd0;
          dma_dat_d = 16'h4000;
          rd_idx_d  = 2'd1;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        if (!dm_req_q) begin
          dm_req_d = 1'b1;
          dm_we_d  = 1'b0;
          dm_adr_d = cur_base_q + {19'd0, rd_idx_q, 1'b0};
        end else if (bus_ok) begin
          dm_req_d  = 1'b0;
          dma_stb_d = 1'b1;
          dma_we_d  = 1'b1;
          dma_adr_d = {1'b0, rd_idx_q};
          dma_dat_d = dm_dat_i;
          if (rd_idx_q == 2'd1) w1_d = dm_dat_i;
          if (rd_idx_q == 2'd2) w2_d = dm_dat_i;
          state_d   = S_STORE;
        end
      end
      S_STORE: begin
        if (rd_idx_q == 2'd3) begin
          state_d = S_CHK;
        end else begin
          rd_idx_d = rd_idx_q + 2'd1;
          state_d  = S_RD;
        end
      end
      S_CHK: begin
        if (!w1_q[15]) begin
          eol_d   = 1'b1;
          valid_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (!w1_q[14]) begin
          valid_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (chain_q != 4'hF) begin
          chain_d    = chain_q + 4'd1;
          cur_base_d = {w1_q[5:0], w2_q[15:1], 1'b0};
          state_d    = S_FLAG;
        end else begin
          cherr_d = 1'b1;
          valid_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_SW2: begin
        if (!dm_req_q) begin
          dm_req_d = 1'b1;
          dm_we_d  = 1'b1;
          dm_adr_d = cur_base_q + 22'd10;
          dm_dat_d = sw2_i;
        end else if (bus_ok) begin
          dm_req_d  = 1'b0;
          dma_stb_d = 1'b1;
          dma_we_d  = 1'b1;
          dma_adr_d = 3'd5;
          dma_dat_d = dm_dat_q;
          state_d   = S_SW1;
        end
      end
      S_SW1: begin
        if (!dm_req_q) begin
          dm_req_d = 1'b1;
          dm_we_d  = 1'b1;
          dm_adr_d = cur_base_q + 22'd8;
          dm_dat_d = sw1_i;
        end else if (bus_ok) begin
          dm_req_d  = 1'b0;
          dma_stb_d = 1'b1;
          dma_we_d  = 1'b1;
          dma_adr_d = 3'd4;
          dma_dat_d = dm_dat_q;
          valid_d   = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A bus error in any DMA state aborts the whole operation without touching the register file.
    if (bus_err) begin
      dm_req_d  = 1'b0;
      dma_stb_d = 1'b0;
      dma_we_d  = 1'b0;
      nxm_d     = 1'b1;
      valid_d   = 1'b0;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = S_DONE;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= S_IDLE;
      cur_base_q <= 22'd0;
      chain_q    <= 4'd0;
      rd_idx_q   <= 2'd0;
      w1_q       <= 16'd0;
      w2_q       <= 16'd0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_adr_q   <= 22'd0;
      dm_dat_q   <= 16'd0;
      dma_adr_q  <= 3'd0;
      dma_dat_q  <= 16'd0;
      dma_we_q   <= 1'b0;
      dma_stb_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      eol_q      <= 1'b0;
      nxm_q      <= 1'b0;
      cherr_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_base_q <= cur_base_d;
      chain_q    <= chain_d;
      rd_idx_q   <= rd_idx_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_adr_q   <= dm_adr_d;
      dm_dat_q   <= dm_dat_d;
      dma_adr_q  <= dma_adr_d;
      dma_dat_q  <= dma_dat_d;
      dma_we_q   <= dma_we_d;
      dma_stb_q  <= dma_stb_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      eol_q      <= eol_d;
      nxm_q      <= nxm_d;
      cherr_q    <= cherr_d;
      done_q     <= done_d;
    end
  end

  assign dm_req_o  = dm_req_q;
  assign dm_we_o   = dm_we_q;
  assign dm_adr_o  = dm_adr_q;
  assign dm_dat_o  = dm_dat_q;
  assign dma_adr_o = dma_adr_q;
  assign dma_dat_o = dma_dat_q;
  assign dma_we_o  = dma_we_q;
  assign dma_stb_o = dma_stb_q;
  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign eol_o     = eol_q;
  assign nxm_o     = nxm_q;
  assign cherr_o   = cherr_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_bdl_ctl.sv
// tb/tb_bdl_ctl.sv - directed bench for bdl_ctl
// Memory responder with latency/stall/error injection; register-file and bus-write capture.
module tb_bdl_ctl;

  logic        clk, rst_n;
  logic        fetch_i, wrst_i;
  logic [21:0] base_i;
  logic [15:0] sw1_i, sw2_i;
  logic        dm_req_o, dm_we_o;
  logic [21:0] dm_adr_o;
  logic [15:0] dm_dat_o, dm_dat_i;
  logic        dm_ack_i, dm_err_i;
  logic [2:0]  dma_adr_o;
  logic [15:0] dma_dat_o;
  logic        dma_we_o, dma_stb_o;
  logic        busy_o, valid_o, eol_o, nxm_o, cherr_o, done_o;

  bdl_ctl dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .fetch_i(fetch_i), .wrst_i(wrst_i),
    .base_i(base_i), .sw1_i(sw1_i), .sw2_i(sw2_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_adr_o(dm_adr_o), .dm_dat_o(dm_dat_o),
    .dm_dat_i(dm_dat_i), .dm_ack_i(dm_ack_i), .dm_err_i(dm_err_i),
    .dma_adr_o(dma_adr_o), .dma_dat_o(dma_dat_o), .dma_we_o(dma_we_o), .dma_stb_o(dma_stb_o),
    .busy_o(busy_o), .valid_o(valid_o), .eol_o(eol_o), .nxm_o(nxm_o),
    .cherr_o(cherr_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [21:0] adr; logic [15:0] dat;} wr_t;

  logic [15:0] mem [logic [21:0]];
  wr_t         wlog[$];
  logic [21:0] rlog[$];
  logic [15:0] rf [8];
  int          latency, lat;
  logic        stall_rd, err_en;
  logic [21:0] err_adr;
  int          viol, stb_nowe;
  logic        prev_req, prev_we, prev_resp;
  logic [21:0] prev_adr;
  logic [15:0] prev_dat;
  int          checks, errors;

  // Bus slave and protocol monitor; responses are driven mid-cycle for the next rising edge.
  always @(negedge clk) begin
    if (rst_n && dm_req_o && dm_adr_o[0]) viol++;
    if (rst_n && dm_req_o && prev_req) begin
      if (prev_resp) viol++;
      else if (dm_adr_o !== prev_adr || dm_we_o !== prev_we || (dm_we_o && dm_dat_o !== prev_dat)) viol++;
    end
    if (dma_stb_o && !dma_we_o) stb_nowe++;
    if (dma_stb_o && dma_we_o) rf[dma_adr_o] = dma_dat_o;
    prev_req = dm_req_o;
    prev_adr = dm_adr_o;
    prev_we  = dm_we_o;
    prev_dat = dm_dat_o;
    if (!rst_n) begin
      dm_ack_i = 1'b0; dm_err_i = 1'b0; lat = 0;
    end else if (dm_ack_i || dm_err_i) begin
      dm_ack_i = 1'b0; dm_err_i = 1'b0;
    end else if (dm_req_o && !(stall_rd && !dm_we_o)) begin
      if (lat < latency) lat++;
      else begin
        lat = 0;
        if (!dm_we_o) rlog.push_back(dm_adr_o);
        if (err_en && dm_adr_o == err_adr) dm_err_i = 1'b1;
        else begin
          dm_ack_i = 1'b1;
          if (dm_we_o) wlog.push_back('{dm_adr_o, dm_dat_o});
          else dm_dat_i = mem.exists(dm_adr_o) ? mem[dm_adr_o] : 16'h0000;
        end
      end
    end
    prev_resp = dm_ack_i || dm_err_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_fetch(input logic [21:0] b);
    base_i = b; fetch_i = 1'b1;
    @(negedge clk);
    fetch_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, {31'd0, done_o}, 32'd1);
    chk({tag, " busy at done"}, {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk({tag, " done width"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int wb, rb, n;
    logic [21:0] a;
    checks = 0; errors = 0;
    rst_n = 1'b0; fetch_i = 1'b0; wrst_i = 1'b0; base_i = 22'd0;
    sw1_i = 16'd0; sw2_i = 16'd0;
    latency = 2; stall_rd = 1'b0; err_en = 1'b0; err_adr = 22'd0;
    repeat (3) @(negedge clk);
    chk("reset dm_req", {31'd0, dm_req_o}, 32'd0);
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    chk("reset valid", {31'd0, valid_o}, 32'd0);
    chk("reset done", {31'd0, done_o}, 32'd0);
    chk("reset stb", {31'd0, dma_stb_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain descriptor with slow memory
    mem[22'h001002] = 16'h8012; mem[22'h001004] = 16'h3400; mem[22'h001006] = 16'hFF00;
    wb = wlog.size(); rb = rlog.size();
    pulse_fetch(22'h001000);
    chk("t1 busy", {31'd0, busy_o}, 32'd1);
    wait_done("t1");
    chk("t1 nwrites", wlog.size() - wb, 32'd1);
    chk("t1 flag adr", {10'd0, wlog[wb].adr}, 32'h001000);
    chk("t1 flag dat", {16'd0, wlog[wb].dat}, 32'h4000);
    chk("t1 nreads", rlog.size() - rb, 32'd3);
    chk("t1 rd0", {10'd0, rlog[rb]}, 32'h001002);
    chk("t1 rd1", {10'd0, rlog[rb+1]}, 32'h001004);
    chk("t1 rd2", {10'd0, rlog[rb+2]}, 32'h001006);
    chk("t1 rf0", {16'd0, rf[0]}, 32'h4000);
    chk("t1 rf1", {16'd0, rf[1]}, 32'h8012);
    chk("t1 rf2", {16'd0, rf[2]}, 32'h3400);
    chk("t1 rf3", {16'd0, rf[3]}, 32'hFF00);
    chk("t1 valid", {31'd0, valid_o}, 32'd1);
    chk("t1 eol", {31'd0, eol_o}, 32'd0);

    // Status writeback
    latency = 1; sw1_i = 16'h2000; sw2_i = 16'h0060;
    wb = wlog.size();
    wrst_i = 1'b1; @(negedge clk); wrst_i = 1'b0;
    wait_done("wb");
    chk("wb nwrites", wlog.size() - wb, 32'd2);
    chk("wb sw2 adr", {10'd0, wlog[wb].adr}, 32'h00100A);
    chk("wb sw2 dat", {16'd0, wlog[wb].dat}, 32'h0060);
    chk("wb sw1 adr", {10'd0, wlog[wb+1].adr}, 32'h001008);
    chk("wb sw1 dat", {16'd0, wlog[wb+1].dat}, 32'h2000);
    chk("wb rf5", {16'd0, rf[5]}, 32'h0060);
    chk("wb rf4", {16'd0, rf[4]}, 32'h2000);
    chk("wb valid", {31'd0, valid_o}, 32'd0);

    // Writeback request with no valid descriptor is dropped
    wb = wlog.size();
    wrst_i = 1'b1; @(negedge clk); wrst_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("wrst ignored writes", wlog.size() - wb, 32'd0);
    chk("wrst ignored busy", {31'd0, busy_o}, 32'd0);

    // Two-descriptor chain; a fetch mid-operation must be ignored
    latency = 0;
    mem[22'h002002] = 16'hC001; mem[22'h002004] = 16'h2000; mem[22'h002006] = 16'h0010;
    mem[22'h012002] = 16'h8000; mem[22'h012004] = 16'h0000; mem[22'h012006] = 16'h0000;
    wb = wlog.size();
    pulse_fetch(22'h002000);
    @(negedge clk);
    pulse_fetch(22'h3F0000);
    wait_done("chain");
    chk("chain nwrites", wlog.size() - wb, 32'd2);
    chk("chain flag1 adr", {10'd0, wlog[wb].adr}, 32'h002000);
    chk("chain flag2 adr", {10'd0, wlog[wb+1].adr}, 32'h012000);
    chk("chain valid", {31'd0, valid_o}, 32'd1);
    chk("chain cherr", {31'd0, cherr_o}, 32'd0);

    // Sixteen linked descriptors exhaust the chain counter
    for (int k = 0; k < 16; k++) begin
      a = 22'h020000 + 22'(k * 16);
      mem[a + 22'd2] = 16'hC002;
      mem[a + 22'd4] = 16'((k + 1) * 16);
      mem[a + 22'd6] = 16'h0000;
    end
    wb = wlog.size();
    pulse_fetch(22'h020000);
    wait_done("c16");
    chk("c16 flag writes", wlog.size() - wb, 32'd16);
    chk("c16 last flag adr", {10'd0, wlog[wb+15].adr}, 32'h0200F0);
    chk("c16 cherr", {31'd0, cherr_o}, 32'd1);
    chk("c16 valid", {31'd0, valid_o}, 32'd0);
    chk("c16 rf2", {16'd0, rf[2]}, 32'h0100);

    // Bus error on the second read
    mem[22'h003002] = 16'h8000; mem[22'h003004] = 16'h1234;
    err_en = 1'b1; err_adr = 22'h003004;
    rb = rlog.size();
    pulse_fetch(22'h003000);
    wait_done("nxm");
    err_en = 1'b0;
    chk("nxm flag", {31'd0, nxm_o}, 32'd1);
    chk("nxm valid", {31'd0, valid_o}, 32'd0);
    chk("nxm cherr cleared", {31'd0, cherr_o}, 32'd0);
    chk("nxm rf1", {16'd0, rf[1]}, 32'h8000);
    chk("nxm rf2 kept", {16'd0, rf[2]}, 32'h0100);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (dm_req_o) n++;
    end
    chk("nxm no more req", n, 32'd0);
    chk("nxm nreads", rlog.size() - rb, 32'd2);

    // Reset while a read is stalled
    stall_rd = 1'b1;
    mem[22'h004002] = 16'h8000;
    pulse_fetch(22'h004000);
    n = 0;
    while (!(dm_req_o && !dm_we_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst stalled read", {31'd0, dm_req_o && !dm_we_o}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst req drop", {31'd0, dm_req_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst nxm", {31'd0, nxm_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; stall_rd = 1'b0;
    @(negedge clk);
    mem[22'h005002] = 16'h8000; mem[22'h005004] = 16'h0000; mem[22'h005006] = 16'h0000;
    wb = wlog.size();
    pulse_fetch(22'h005001);
    wait_done("post rst");
    chk("post rst flag adr", {10'd0, wlog[wb].adr}, 32'h005000);
    chk("post rst valid", {31'd0, valid_o}, 32'd1);

    // End of list
    mem[22'h006002] = 16'h0000; mem[22'h006004] = 16'h0000; mem[22'h006006] = 16'h0000;
    pulse_fetch(22'h006000);
    wait_done("eol");
    chk("eol flag", {31'd0, eol_o}, 32'd1);
    chk("eol valid", {31'd0, valid_o}, 32'd0);

    chk("bus stability", viol, 32'd0);
    chk("stb without we", stb_nowe, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
